mc_control: RTL

- Multicycle main controller that sequences the shared single-memory MIPS datapath one instruction at a time.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK states.
- Drives the mux selects, write strobes and ALU code for the datapath.
- Stalls on a memory ready handshake.
- Sits beside pc, regfile, alu and the unified memory, and replaces the combinational controlunit in the multicycle build.

---
 rtl/mc_control_pkg.sv | 54 +++++
 rtl/mc_control_alu_decoder.sv | 31 +++
 rtl/mc_control.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mc_control_pkg.sv
// mc_defs: shared encodings for the multicycle main controller.
package mc_defs;

  // Controller states, 4-bit encoding.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  // Opcodes (instruction[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction[5:0]).
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU_Control codes.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALUSrcB selects.
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PCSource selects.
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_alu_decoder.sv
// alu_decoder: R-type funct to ALU_Control, flags unsupported funct codes.
module alu_decoder
  import mc_defs::*;
#(
  parameter int OPW   = 6,
  parameter int ALUCW = 4
) (
  input  logic [OPW-1:0]   funct,
  output logic [ALUCW-1:0] alu_ctl,
  output logic             illegal
);

  logic [3:0] w_code;

  // Map funct to an ALU operation; unknown codes fall back to ADD and raise illegal.
  always_comb begin
    w_code  = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  w_code = ALU_ADD;
      FN_SUB:  w_code = ALU_SUB;
      FN_AND:  w_code = ALU_AND;
      FN_OR:   w_code = ALU_OR;
      FN_SLT:  w_code = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

  assign alu_ctl = ALUCW'(w_code);

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle main controller for the single-memory MIPS datapath.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 -> PC, load IR on mem_ready
// DECODE | branch target into ALUOut, dispatch on opcode
// MEMADR | base + imm address for lw/sw
// MEMRD  | data read, wait for mem_ready
// MEMWB  | MDR -> rt
// MEMWR  | data write, wait for mem_ready
// RTEX   | R-type ALU op from funct
// RTWB   | ALUOut -> rd
// BEQ    | compare, branch if zero
// ADDIEX | rs + imm
// ADDIWB | ALUOut -> rt
// JUMP   | jump target -> PC
// HALT   | illegal instruction, parked until reset
module mc_control
  import mc_defs::*;
#(
  parameter int OPW   = 6,
  parameter int ALUCW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic [OPW-1:0]   funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [ALUCW-1:0] ALU_Control,
  output logic [1:0]       PCSource,
  output logic             pc_en,
  output logic             instr_done,
  output logic             halted
);

  state_t r_state;
  state_t w_next;
  logic   r_is_store;

  logic [ALUCW-1:0] w_rt_alu;
  logic             w_rt_illegal;

  alu_decoder #(.OPW(OPW), .ALUCW(ALUCW)) u_alu_decoder (
    .funct   (funct),
    .alu_ctl (w_rt_alu),
    .illegal (w_rt_illegal)
  );

  // State register; lw/sw is latched in DECODE so MEMADR needs no opcode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_is_store <= (opcode == OP_SW);
    end
  end

  // Next-state and control decode; everything forced low while reset is held.
  always_comb begin
    w_next      = r_state;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RD2;
    ALU_Control = ALUCW'(ALU_AND);
    PCSource    = PCS_ALU;
    pc_en       = 1'b0;
    instr_done  = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ALU_Control = ALUCW'(ALU_ADD);
        if (mem_ready) begin
          IRWrite = 1'b1;
          pc_en   = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB     = SRCB_IMMSH;
        ALU_Control = ALUCW'(ALU_ADD);
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTEX;
          OP_BEQ:       w_next = S_BEQ;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALU_Control = ALUCW'(ALU_ADD);
        w_next      = r_is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemToReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_RTEX: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_RD2;
        ALU_Control = w_rt_alu;
        w_next      = w_rt_illegal ? S_HALT : S_RTWB;
      end
      S_RTWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_RD2;
        ALU_Control = ALUCW'(ALU_SUB);
        PCSource    = PCS_ALUOUT;
        pc_en       = zero;
        instr_done  = 1'b1;
        w_next      = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALU_Control = ALUCW'(ALU_ADD);
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = PCS_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    if (!rst) begin
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemToReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RD2;
      ALU_Control = '0;
      PCSource    = PCS_ALU;
      pc_en       = 1'b0;
      instr_done  = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule
